// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture buffer.
// State encoding plus ring-address arithmetic.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        READ
    } state_t;

    function automatic logic [31:0] ring_sub(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          aw
    );
        logic [31:0] mask;
        mask = (32'd1 << aw) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM, synchronous write and read.
// Read register only updates when re is high.
module ram_sdp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/capture_buf.sv
// Circular pre/post-trigger capture buffer with
// oldest-first valid/ready readout.
module capture_buf
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int CHANNELS   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arm,
    input  logic [ADDR_WIDTH-1:0]          pretrig,
    input  logic                           sample_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] sample_in,
    input  logic                           trig,
    output logic                           busy,
    output logic                           triggered,
    output logic [ADDR_WIDTH-1:0]          trig_addr,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] rd_data,
    output logic                           rd_last
);

    localparam int W = CHANNELS * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] A1 = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   C1 = (ADDR_WIDTH+1)'(1);

    state_t state, state_n;

    logic [ADDR_WIDTH-1:0] wptr, rptr, count, post, p_reg;
    logic [ADDR_WIDTH-1:0] base, start;
    logic [ADDR_WIDTH:0]   rcnt;
    logic [W-1:0]          ram_q;
    logic                  v1, last1;
    logic                  wr_en, fire, issue, advance;
    logic                  rd_issue, done, enter_read;

    assign wr_en = sample_valid &&
                   (state == PRE || state == WAIT_TRIG ||
                    state == POST);
    assign fire       = state == WAIT_TRIG && sample_valid && trig;
    assign advance    = !rd_valid || rd_ready;
    assign issue      = state == READ && !rcnt[ADDR_WIDTH];
    assign rd_issue   = issue && advance;
    assign done       = state == READ && rd_valid &&
                        rd_ready && rd_last;
    assign enter_read = state != READ && state_n == READ;
    assign busy       = state != IDLE;

    // Oldest sample sits P words before the trigger sample.
    assign base  = (state == WAIT_TRIG) ? wptr : trig_addr;
    assign start = ADDR_WIDTH'(ring_sub(32'(base), 32'(p_reg),
                                        ADDR_WIDTH));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:
                if (arm)
                    state_n = (pretrig == '0) ? WAIT_TRIG : PRE;
            PRE:
                if (sample_valid && count == p_reg - A1)
                    state_n = WAIT_TRIG;
            WAIT_TRIG:
                if (fire)
                    state_n = (&p_reg) ? READ : POST;
            POST:
                if (sample_valid && post == A1)
                    state_n = READ;
            READ:
                if (done)
                    state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            count     <= '0;
            post      <= '0;
            p_reg     <= '0;
            trig_addr <= '0;
            triggered <= 1'b0;
            rptr      <= '0;
            rcnt      <= '0;
            v1        <= 1'b0;
            last1     <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
        end else begin
            if (state == IDLE && arm) begin
                p_reg <= pretrig;
                wptr  <= '0;
                count <= '0;
            end
            if (wr_en)
                wptr <= wptr + A1;
            if (state == PRE && sample_valid)
                count <= count + A1;
            if (fire) begin
                trig_addr <= wptr;
                triggered <= 1'b1;
                post      <= ~p_reg;
            end
            if (state == POST && sample_valid)
                post <= post - A1;
            if (enter_read) begin
                rptr <= start;
                rcnt <= '0;
            end else if (rd_issue) begin
                rptr <= rptr + A1;
                rcnt <= rcnt + C1;
            end
            // Two-stage read pipeline stalls as a whole.
            if (advance) begin
                v1       <= issue;
                last1    <= issue && (&rcnt[ADDR_WIDTH-1:0]);
                rd_valid <= v1;
                rd_data  <= ram_q;
                rd_last  <= last1;
            end
            if (done)
                triggered <= 1'b0;
        end
    end

    ram_sdp #(
        .DATA_WIDTH(W),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wptr),
        .wdata(sample_in),
        .re   (rd_issue),
        .raddr(rptr),
        .rdata(ram_q)
    );

endmodule

// File: tb/tb_capture_buf.sv
// Directed bench for capture_buf (D=16, two channels).
// Captures are table-driven; reset/abort is hand-written.
module tb_capture_buf;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CH = 2;
    localparam int W  = CH * DW;
    localparam int D  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic [AW-1:0] pretrig;
    logic          sample_valid;
    logic [W-1:0]  sample_in;
    logic          trig;
    logic          busy;
    logic          triggered;
    logic [AW-1:0] trig_addr;
    logic          rd_valid;
    logic          rd_ready;
    logic [W-1:0]  rd_data;
    logic          rd_last;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int p;
        int tn;
        int early;
        int arm_n;
        bit bp;
        int rst_beat;
        int first;
        int taddr;
    } vec_t;

    vec_t tv[6];

    capture_buf #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CHANNELS  (CH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .pretrig     (pretrig),
        .sample_valid(sample_valid),
        .sample_in   (sample_in),
        .trig        (trig),
        .busy        (busy),
        .triggered   (triggered),
        .trig_addr   (trig_addr),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_last     (rd_last)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic drive(input int n, input bit v, input bit t);
        logic [7:0] b;
        b = n[7:0];
        sample_valid = v;
        sample_in    = {~b, b};
        trig         = t;
    endtask

    task automatic run(input vec_t v, output bit aborted);
        int         n;
        int         nlast;
        int         beats;
        bit         stall;
        bit         rdy;
        logic [W-1:0] hold;
        logic [7:0] e;
        aborted  = 1'b0;
        arm      = 1'b1;
        pretrig  = AW'(v.p);
        rd_ready = 1'b0;
        drive(0, 1'b0, 1'b0);
        step();
        chk("busy_arm", 32'(busy), 32'd1);
        arm   = 1'b0;
        nlast = v.tn + D - 1 - v.p;
        for (n = 0; n <= nlast; n++) begin
            drive(n, 1'b1, (n == v.tn) || (n == v.early));
            arm     = (n == v.arm_n);
            pretrig = (n == v.arm_n) ? '0 : AW'(v.p);
            step();
        end
        arm      = 1'b0;
        rd_ready = 1'b1;
        drive(n, 1'b1, 1'b0);
        step();
        n++;
        chk("rv_lat1", 32'(rd_valid), 32'd0);
        chk("triggered", 32'(triggered), 32'd1);
        chk("trig_addr", 32'(trig_addr), 32'(v.taddr));
        drive(n, 1'b0, 1'b0);
        step();
        n++;
        chk("rv_lat2", 32'(rd_valid), 32'd1);
        beats = 0;
        stall = 1'b0;
        hold  = '0;
        for (int c = 0; c < 200 && beats < D; c++) begin
            if (stall)
                chk("stable", 32'(rd_data), 32'(hold));
            if (!v.bp)
                chk("no_bubble", 32'(rd_valid), 32'd1);
            if (v.rst_beat == beats && rd_valid) begin
                rst      = 1'b1;
                rd_ready = 1'b0;
                step();
                rst     = 1'b0;
                aborted = 1'b1;
                return;
            end
            rdy = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_ready = rdy;
            drive(n, v.bp ? 1'($urandom_range(0, 1)) : 1'b1,
                  1'b1);
            n++;
            if (rd_valid && rdy) begin
                e = 8'(v.first + beats);
                chk("data", 32'(rd_data), 32'({~e, e}));
                chk("last", 32'(rd_last),
                    32'(beats == D - 1));
                beats++;
            end
            stall = rd_valid && !rdy;
            hold  = rd_data;
            step();
        end
        if (beats < D) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got %0d beats expected %0d",
                     beats, D);
        end
        chk("rv_end", 32'(rd_valid), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("trig_end", 32'(triggered), 32'd0);
        drive(n, 1'b0, 1'b0);
        rd_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_trig"}, 32'(triggered), 32'd0);
        chk({tag, "_taddr"}, 32'(trig_addr), 32'd0);
        chk({tag, "_rvalid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rdata"}, 32'(rd_data), 32'd0);
        chk({tag, "_rlast"}, 32'(rd_last), 32'd0);
    endtask

    initial begin
        bit ab;
        //       p   tn  early arm_n bp rst first taddr
        tv[0] = '{4,  10, -1,  -1,  0, -1,  6, 10};
        tv[1] = '{4,  40, -1,  -1,  0, -1, 36,  8};
        tv[2] = '{8,  12,  3,  -1,  0, -1,  4, 12};
        tv[3] = '{0,   5, -1,  -1,  0, -1,  5,  5};
        tv[4] = '{15, 20, -1,  -1,  0, -1,  5,  4};
        tv[5] = '{4,  10, -1,  -1,  1, -1,  6, 10};

        rst      = 1'b1;
        arm      = 1'b0;
        pretrig  = '0;
        rd_ready = 1'b0;
        drive(0, 1'b0, 1'b0);
        repeat (3) step();
        chk_reset_vals("rst0");
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run(tv[i], ab);
            step();
        end

        // Arm while busy is ignored; reset lands on beat 7.
        run('{4, 10, -1, 2, 0, 6, 6, 10}, ab);
        chk("aborted", 32'(ab), 32'd1);
        chk_reset_vals("rst_mid");
        step();
        run(tv[0], ab);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/capture_buf.md
# capture_buf

Parametrised multi-channel circular capture buffer for the oscilloscope acquisition path. It continuously records samples into an internal ring once armed, then freezes on a trigger after a programmable pre-trigger depth. It then streams the full record out oldest-first over a valid/ready interface. It sits between the ADC sample front-end and the readout/transfer logic, and replaces the plain single-port sample RAM.

## Interface
- DATA_WIDTH, 8, bits per channel sample
- ADDR_WIDTH, 8, record depth D = 2**ADDR_WIDTH words
- CHANNELS, 1, channels stored side by side in one word; W = CHANNELS*DATA_WIDTH
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- arm  in  1  pulse; starts a capture when IDLE, ignored otherwise
- pretrig  in  ADDR_WIDTH  pre-trigger sample count, sampled on accepted arm
- sample_valid  in  1  sample_in carries a new sample this cycle
- sample_in  in  W  channel 0 in bits [DATA_WIDTH-1:0], channel k above it
- trig  in  1  trigger qualifier, only meaningful with sample_valid
- busy  out  1  high in every state except IDLE
- triggered  out  1  trigger accepted; stays high until return to IDLE
- trig_addr  out  ADDR_WIDTH  ring address of the trigger sample
- rd_valid  out  1  rd_data/rd_last valid
- rd_ready  in  1  consumer accepts the beat when rd_valid && rd_ready
- rd_data  out  W  record word
- rd_last  out  1  marks the final (D-th) beat

## Operation
- Modes: IDLE, PRE, WAIT_TRIG, POST, READ. These are held in a state register.
- IDLE: arm=1 -> latch pretrig as P and clear wptr and count. Go to PRE, or to WAIT_TRIG if P=0.
- Write path, in PRE/WAIT_TRIG/POST only: each sample_valid writes mem[wptr] <= sample_in, then wptr <= wptr+1 mod D (wraps silently).
- PRE: count increments per write. When the P-th write occurs -> WAIT_TRIG. trig is ignored in PRE.
- WAIT_TRIG: keeps writing and overwrites the oldest samples. sample_valid && trig -> write that sample (the trigger sample), set trig_addr <= wptr and triggered <= 1, load post = D-1-P.
- Entering POST with post=0 (P=D-1) goes directly to READ.
- POST: each write decrements post. The write taking post to 0 -> READ.
- trig without sample_valid is ignored. trig in POST/READ is ignored.
- READ: rptr starts at trig_addr - P mod D. Emits exactly D beats in ascending ring order: P pre-trigger samples, the trigger sample, then D-1-P post samples. rd_last is set on beat D.
- READ: sample_valid is ignored; the memory is frozen.
- After the rd_last beat is accepted -> IDLE, with triggered <= 0 and rd_valid <= 0.
- arm while busy: no effect.
- rst in any state, including mid-readout: IDLE next cycle, all outputs to reset values. Memory contents are undefined, and no clearing is needed.

## Timing
- Reset values: busy=0, triggered=0, trig_addr=0, rd_valid=0, rd_data=0, rd_last=0.
- arm accepted at edge N -> busy=1 from cycle N+1. The first sample can be written in cycle N+1.
- The write is synchronous. A sample presented in cycle c is readable from cycle c+1.
- Memory read is synchronous, one cycle.
- rd_valid rises exactly 2 cycles after the final POST write edge: one cycle for state entry, one for read latency.
- rd_data and rd_last are registered outputs. They hold stable while rd_valid && !rd_ready.
- Full throughput: with rd_ready held high, one beat per cycle and no bubbles, so D beats take D consecutive cycles.
- rd_valid deasserts the cycle after the rd_last handshake.

## Structure
- Package capture_pkg: the state enum (IDLE, PRE, WAIT_TRIG, POST, READ) and the helper function for ring address subtraction mod D.
- Sub-module ram_sdp: simple dual-port RAM with a synchronous write port, a synchronous read port and parameters DATA_WIDTH=W and ADDR_WIDTH. It has no tri-state and no chip select.
- The top contains the FSM, the wptr/rptr/count/post counters and the output register.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4 (D=16), CHANNELS=2. Stimulus sample_in = {~n, n} for n = 0,1,2,... with sample_valid=1 every cycle.
- Basic: P=4, trig with sample n=10, rd_ready=1 -> triggered=1 and trig_addr=10. Readout is low-byte 6..21 over 16 consecutive cycles, high byte = bitwise inverse, rd_last only on 21.
- Wrap: P=4, trig at n=40 -> trig_addr=8 (40 mod 16). Readout is 36..51.
- Early trig ignored: P=8, trig asserted at n=3 and again at n=12 -> capture triggers on 12. Readout is 4..19.
- Edges: P=0 with trig at n=5 -> readout 5..20. P=15 with trig at n=20 -> readout 5..20, with rd_valid exactly 2 cycles after the trigger write.
- Backpressure: random rd_ready (about 50%) -> the same sequence as with rd_ready=1. rd_data is stable while stalled, and sample_valid toggling during READ does not alter data.
- Reset/arm: rst during beat 7 -> all outputs 0 next cycle and busy=0. arm pulses while busy are ignored. A fresh arm then captures correctly.
